// File: rtl/mul_div_unit.sv
// Iterative HI/LO multiply/divide unit: radix-2 shift-add multiply and restoring
// divide on operand magnitudes, with the sign correction applied in a final FIX cycle.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic [2:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int PW = 2 * WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sgn_q, sgn_d;
    logic             div_q, div_d;
    logic             aneg_q, aneg_d;
    logic             bneg_q, bneg_d;
    logic             bz_q, bz_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] hw_q, hw_d;
    logic [WIDTH-1:0] lw_q, lw_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   mul_sum, div_sh;
    logic [WIDTH-1:0] mul_hi, mul_lo, div_hi, div_lo;
    logic [PW-1:0]    prod, prod_fix;
    logic [WIDTH-1:0] quo_fix, rem_fix;

    assign a_mag = (Op[0] && A[WIDTH-1]) ? (~A + WIDTH'(1)) : A;
    assign b_mag = (Op[0] && B[WIDTH-1]) ? (~B + WIDTH'(1)) : B;

    // Working pair {hw,lw}: product accumulator / {remainder, shifting dividend->quotient}.
    assign mul_sum = {1'b0, hw_q} + (lw_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
    assign mul_hi  = mul_sum[WIDTH:1];
    assign mul_lo  = {mul_sum[0], lw_q[WIDTH-1:1]};

    assign div_sh  = {hw_q, lw_q[WIDTH-1]};
    always_comb begin
        div_hi = div_sh[WIDTH-1:0];
        div_lo = {lw_q[WIDTH-2:0], 1'b0};
        if (div_sh >= {1'b0, b_q}) begin
            div_hi = WIDTH'(div_sh - {1'b0, b_q});
            div_lo = {lw_q[WIDTH-2:0], 1'b1};
        end
    end

    assign prod     = {hw_q, lw_q};
    assign prod_fix = (sgn_q && (aneg_q ^ bneg_q)) ? (~prod + PW'(1)) : prod;
    assign quo_fix  = (sgn_q && (aneg_q ^ bneg_q)) ? (~lw_q + WIDTH'(1)) : lw_q;
    assign rem_fix  = (sgn_q && aneg_q) ? (~hw_q + WIDTH'(1)) : hw_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sgn_d   = sgn_q;
        div_d   = div_q;
        aneg_d  = aneg_q;
        bneg_d  = bneg_q;
        bz_d    = bz_q;
        a_d     = a_q;
        b_d     = b_q;
        hw_d    = hw_q;
        lw_d    = lw_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    if (!Op[2]) begin
                        state_d = S_RUN;
                        cnt_d   = CW'(WIDTH);
                        sgn_d   = Op[0];
                        div_d   = Op[1];
                        aneg_d  = Op[0] & A[WIDTH-1];
                        bneg_d  = Op[0] & B[WIDTH-1];
                        bz_d    = (B == '0);
                        a_d     = A;
                        b_d     = b_mag;
                        hw_d    = '0;
                        lw_d    = a_mag;
                    end else if (Op == 3'd4) begin
                        hi_d = A;
                    end else if (Op == 3'd5) begin
                        lo_d = A;
                    end
                end
            end
            S_RUN: begin
                hw_d  = div_q ? div_hi : mul_hi;
                lw_d  = div_q ? div_lo : mul_lo;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = S_FIX;
            end
            S_FIX: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
                if (!div_q) begin
                    {hi_d, lo_d} = prod_fix;
                end else if (bz_q) begin
                    // Divide by zero returns the raw dividend, never sign-adjusted.
                    hi_d = a_q;
                    lo_d = '1;
                end else begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sgn_q   <= 1'b0;
            div_q   <= 1'b0;
            aneg_q  <= 1'b0;
            bneg_q  <= 1'b0;
            bz_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            hw_q    <= '0;
            lw_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sgn_q   <= sgn_d;
            div_q   <= div_d;
            aneg_q  <= aneg_d;
            bneg_q  <= bneg_d;
            bz_q    <= bz_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hw_q    <= hw_d;
            lw_q    <= lw_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign Busy = (state_q != S_IDLE);
    assign Done = done_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, operand/result width, legal range 4..64.
REQ-002 The block SHALL have port Clock, input, 1 bit, sole clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port Reset, input, 1 bit, reset that is asynchronous and active-high.
REQ-004 The block SHALL have port Start, input, 1 bit, request strobe, sampled only while idle.
REQ-005 The block SHALL have port Op, input, 3 bits, operation code: 0 MULTU, 1 MULT, 2 DIVU, 3 DIV, 4 MTHI, 5 MTLO; 6 and 7 reserved.
REQ-006 The block SHALL have port A, input, WIDTH bits, multiplicand/dividend/move source.
REQ-007 The block SHALL have port B, input, WIDTH bits, multiplier/divisor.
REQ-008 The block SHALL have port Busy, output, 1 bit, high while an iterative operation is in progress.
REQ-009 The block SHALL have port Done, output, 1 bit, single-cycle completion pulse for ops 0-3.
REQ-010 The block SHALL have port HI, output, WIDTH bits, architectural HI register.
REQ-011 The block SHALL have port LO, output, WIDTH bits, architectural LO register.

Function
REQ-012 The block SHALL implement states IDLE, RUN, FIX; Busy SHALL equal (state != IDLE).
REQ-013 The block SHALL capture Op, A, B at edge k when Start=1, state=IDLE and Op is 0-3, then enter RUN with an iteration counter of WIDTH.
REQ-014 The block SHALL perform one radix-2 iteration per RUN cycle: shift-add for multiply, restoring subtract for divide; after WIDTH iterations, at edge k+WIDTH, it SHALL enter FIX.
REQ-015 At edge k+WIDTH+1 the block SHALL apply the sign correction, write HI/LO, assert Done for exactly one cycle, and return to IDLE.
REQ-016 Total latency from the Start-capturing edge to Done SHALL be WIDTH+1 cycles, independent of operand values.
REQ-017 HI and LO SHALL hold their previous values throughout RUN and FIX, using separate working registers.
REQ-018 MULT/MULTU SHALL produce the 2*WIDTH-bit product, signed or unsigned respectively, with {HI,LO} = product.
REQ-019 DIV/DIVU SHALL place the quotient in LO and the remainder in HI; signed quotient SHALL truncate toward zero, and the signed remainder SHALL take the sign of the dividend.
REQ-020 For signed ops, the block SHALL iterate on magnitudes; the sign fix SHALL be performed only in FIX.
REQ-021 On divide by zero (ops 2/3, B=0), the block SHALL write LO = all ones and HI = A unmodified, with no sign fix and the same latency.
REQ-022 For DIV with A = most-negative and B = -1, the block SHALL write LO = most-negative and HI = 0 (wrap, no trap).
REQ-023 When Start=1 in IDLE with Op=4 (MTHI) or Op=5 (MTLO), the block SHALL write A into HI or LO respectively at that edge; Busy and Done SHALL stay 0.
REQ-024 The block SHALL ignore Start while Busy=1, for any Op.
REQ-025 The block SHALL ignore Start with a reserved Op (6 or 7) and leave all state unchanged.
REQ-026 The block SHALL accept Start in the cycle Done=1, since the state is then IDLE; Done SHALL still fall after one cycle.

Reset
REQ-027 Reset=1 SHALL immediately force state=IDLE, Busy=0, Done=0, HI=0, LO=0, counter=0, and clear working registers, regardless of Clock.
REQ-028 Reset asserted mid-RUN or mid-FIX SHALL abort the operation with no Done pulse; the first Start after reset deasserts SHALL be processed normally.

Verification (WIDTH=32)
REQ-029 The bench SHALL cover: MULTU A=0xFFFFFFFF B=0xFFFFFFFF -> Done 33 cycles after the Start edge, HI=0xFFFFFFFE, LO=0x00000001, and Busy high for 33 cycles.
REQ-030 The bench SHALL cover: MULT A=0xFFFFFFFD (-3) B=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; and DIV A=0xFFFFFFF9 (-7) B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-031 The bench SHALL cover: DIVU A=100 B=0 -> LO=0xFFFFFFFF, HI=0x00000064; and DIV A=0x80000000 B=0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-032 The bench SHALL cover: MTLO A=0x1234 -> LO=0x1234 next cycle with Busy=0 and Done=0; a second Start (DIVU) issued while a MULTU is busy -> ignored, and only the MULTU result is written.
REQ-033 The bench SHALL cover: Reset pulsed 10 cycles into a DIVU -> Busy, Done, HI and LO read 0 before the next Clock edge, with no Done pulse; a following MULTU 6*7 -> LO=42, HI=0.
REQ-034 The bench SHALL cover: back-to-back operations with Start held in the Done cycle -> the second op is accepted, and its Done follows 33 cycles later.
